// File: rtl/video_timing_gen.sv
// video_timing_gen
//
// Parametrised raster timing generator. Produces pixel/line counters, blanking,
// sync, line/frame start strobes and blank-gated RGB for a video mode fixed at
// elaboration. All state advances only on PCLK edges where PCEN is high, so the
// block can run from a system clock faster than the pixel rate.
//
// Runtime sync offsets (HOFFS/VOFFS) are signed, clamped into the porches and
// latched only at the last pixel of a frame, so centring changes never tear.
//
// Ports:
//   PCLK    in   clock
//   RESET   in   synchronous active-high reset (takes effect regardless of PCEN)
//   PCEN    in   pixel clock enable
//   iRGB    in   pixel data for the current HPOS/VPOS
//   HOFFS   in   signed horizontal sync shift (pixels)
//   VOFFS   in   signed vertical sync shift (lines)
//   HPOS    out  hcnt + HPOS_BASE (mod 2^CW)
//   VPOS    out  vcnt
//   HBLK    out  horizontal blanking
//   VBLK    out  vertical blanking
//   HSYN    out  horizontal sync, active level HS_POL
//   VSYN    out  vertical sync, active level VS_POL
//   LSTART  out  high while hcnt = 0 is presented
//   FSTART  out  high while hcnt = 0 and vcnt = 0 are presented
//   oRGB    out  iRGB registered one PCEN tick later, zero when it was blanked

module video_timing_gen #(
  parameter int CW        = 9,
  parameter int RGB_W     = 8,
  parameter int H_ACTIVE  = 256,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 72,
  parameter int V_ACTIVE  = 224,
  parameter int V_FP      = 16,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 20,
  parameter int HPOS_BASE = 0,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic             PCLK,
  input  logic             RESET,
  input  logic             PCEN,
  input  logic [RGB_W-1:0] iRGB,
  input  logic [3:0]       HOFFS,
  input  logic [3:0]       VOFFS,
  output logic [CW-1:0]    HPOS,
  output logic [CW-1:0]    VPOS,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYN,
  output logic             VSYN,
  output logic             LSTART,
  output logic             FSTART,
  output logic [RGB_W-1:0] oRGB
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Two extra bits: one for sign, one so that start + offset never wraps.
  localparam int SW      = CW + 2;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_BASE  = CW'(HPOS_BASE);

  localparam logic signed [SW-1:0] HS_START = SW'(H_ACTIVE + H_FP);
  localparam logic signed [SW-1:0] HS_LEN   = SW'(H_SYNC - 1);
  localparam logic signed [SW-1:0] VS_START = SW'(V_ACTIVE + V_FP);
  localparam logic signed [SW-1:0] VS_LEN   = SW'(V_SYNC - 1);

  // Sign-extend a 4-bit offset and clamp it into [-fp, bp].
  function automatic logic signed [SW-1:0] clamp_offs(input logic [3:0] offs,
                                                      input int fp, input int bp);
    int v;
    v = int'($signed(offs));
    if (v < -fp) begin
      v = -fp;
    end else if (v > bp) begin
      v = bp;
    end
    return SW'(v);
  endfunction

  // Counter and offset state
  logic [CW-1:0]        hcnt_q, hcnt_d;
  logic [CW-1:0]        vcnt_q, vcnt_d;
  logic signed [SW-1:0] ho_q, ho_d;
  logic signed [SW-1:0] vo_q, vo_d;
  // Set by reset: the first enabled tick afterwards presents (0,0) again
  // instead of advancing, so the decodes for that point are shown.
  logic                 first_q;

  // Registered decodes
  logic             hblk_q, vblk_q, hsyn_q, vsyn_q, lstart_q, fstart_q;
  logic [RGB_W-1:0] rgb_q;

  // Next-state decodes
  logic                 hblk_d, vblk_d, hsyn_d, vsyn_d, lstart_d, fstart_d;
  logic signed [SW-1:0] h_s, v_s;
  logic signed [SW-1:0] hs_lo, hs_hi, vs_lo, vs_hi;
  logic                 hs_act, vs_act;

  // Counter advance and frame-boundary offset latch
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    ho_d   = ho_q;
    vo_d   = vo_q;
    if (!first_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          ho_d   = clamp_offs(HOFFS, H_FP, H_BP);
          vo_d   = clamp_offs(VOFFS, V_FP, V_BP);
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Decodes from the next-state counters so the registered flags line up
  // with the counter values they describe. The new offsets apply to the
  // frame that starts on the same tick they are latched.
  always_comb begin
    h_s    = {2'b00, hcnt_d};
    v_s    = {2'b00, vcnt_d};
    hs_lo  = HS_START + ho_d;
    hs_hi  = hs_lo + HS_LEN;
    vs_lo  = VS_START + vo_d;
    vs_hi  = vs_lo + VS_LEN;
    hs_act = (h_s >= hs_lo) && (h_s <= hs_hi);
    vs_act = (v_s >= vs_lo) && (v_s <= vs_hi);

    hblk_d   = (hcnt_d >= H_ACT_C);
    vblk_d   = (vcnt_d >= V_ACT_C);
    hsyn_d   = hs_act ? HS_POL : ~HS_POL;
    vsyn_d   = vs_act ? VS_POL : ~VS_POL;
    lstart_d = (hcnt_d == '0);
    fstart_d = (hcnt_d == '0) && (vcnt_d == '0);
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      ho_q     <= '0;
      vo_q     <= '0;
      first_q  <= 1'b1;
      hblk_q   <= 1'b1;
      vblk_q   <= 1'b1;
      hsyn_q   <= ~HS_POL;
      vsyn_q   <= ~VS_POL;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
      rgb_q    <= '0;
    end else if (PCEN) begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      ho_q     <= ho_d;
      vo_q     <= vo_d;
      first_q  <= 1'b0;
      hblk_q   <= hblk_d;
      vblk_q   <= vblk_d;
      hsyn_q   <= hsyn_d;
      vsyn_q   <= vsyn_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
      // Gate with the flags describing the pixel iRGB belongs to.
      rgb_q    <= (hblk_q || vblk_q) ? '0 : iRGB;
    end
  end

  assign HPOS   = hcnt_q + H_BASE;
  assign VPOS   = vcnt_q;
  assign HBLK   = hblk_q;
  assign VBLK   = vblk_q;
  assign HSYN   = hsyn_q;
  assign VSYN   = vsyn_q;
  assign LSTART = lstart_q;
  assign FSTART = fstart_q;
  assign oRGB   = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-mode instance checked against a table of
// horizontal landmarks, and a small-mode instance (short frames) checked every
// cycle against a behavioural scoreboard plus directed offset/reset sequences.

module tb_video_timing_gen;

  // Small mode: 32 x 21 total, base offset wraps HPOS, active-high HSYN.
  localparam int SHA = 16, SHF = 4, SHS = 4, SHB = 8;
  localparam int SVA = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SBASE = 40;

  logic       PCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PCEN = 1'b0;
  logic [7:0] irgb_df = 8'h00, irgb_sm = 8'h00;
  logic [3:0] hoffs_df = 4'h0, voffs_df = 4'h0, hoffs_sm = 4'h0, voffs_sm = 4'h0;

  logic [8:0] hpos_df, vpos_df;
  logic       hblk_df, vblk_df, hsyn_df, vsyn_df, lstart_df, fstart_df;
  logic [7:0] orgb_df;
  logic [5:0] hpos_sm, vpos_sm;
  logic       hblk_sm, vblk_sm, hsyn_sm, vsyn_sm, lstart_sm, fstart_sm;
  logic [7:0] orgb_sm;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  video_timing_gen dut_df (
    .PCLK(PCLK), .RESET(RESET), .PCEN(PCEN), .iRGB(irgb_df),
    .HOFFS(hoffs_df), .VOFFS(voffs_df),
    .HPOS(hpos_df), .VPOS(vpos_df), .HBLK(hblk_df), .VBLK(vblk_df),
    .HSYN(hsyn_df), .VSYN(vsyn_df), .LSTART(lstart_df), .FSTART(fstart_df),
    .oRGB(orgb_df)
  );

  video_timing_gen #(
    .CW(6), .RGB_W(8),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HPOS_BASE(SBASE), .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_sm (
    .PCLK(PCLK), .RESET(RESET), .PCEN(PCEN), .iRGB(irgb_sm),
    .HOFFS(hoffs_sm), .VOFFS(voffs_sm),
    .HPOS(hpos_sm), .VPOS(vpos_sm), .HBLK(hblk_sm), .VBLK(vblk_sm),
    .HSYN(hsyn_sm), .VSYN(vsyn_sm), .LSTART(lstart_sm), .FSTART(fstart_sm),
    .oRGB(orgb_sm)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- small-mode scoreboard ----------------
  typedef struct packed {
    logic [5:0] hpos;
    logic [5:0] vpos;
    logic       hblk, vblk, hsyn, vsyn, ls, fs;
    logic [7:0] orgb;
  } sb_t;

  sb_t sb_q[$];
  sb_t m_prev;
  bit  m_started;
  int  m_h, m_v, m_ho, m_vo;

  function automatic int clampi(input logic [3:0] x, input int fp, input int bp);
    int v;
    v = int'($signed(x));
    if (v < -fp) v = -fp;
    if (v > bp) v = bp;
    return v;
  endfunction

  function automatic sb_t decode();
    sb_t e;
    e      = '0;
    e.hpos = 6'((m_h + SBASE) % 64);
    e.vpos = 6'(m_v);
    e.hblk = (m_h >= SHA);
    e.vblk = (m_v >= SVA);
    e.hsyn = (m_h >= SHA + SHF + m_ho) && (m_h <= SHA + SHF + m_ho + SHS - 1);
    e.vsyn = !((m_v >= SVA + SVF + m_vo) && (m_v <= SVA + SVF + m_vo + SVS - 1));
    e.ls   = (m_h == 0);
    e.fs   = (m_h == 0) && (m_v == 0);
    return e;
  endfunction

  // One PCLK cycle: predict the small instance, clock, then compare.
  task automatic tick();
    sb_t e, got;
    irgb_sm = 8'($urandom);
    if (RESET) begin
      m_started = 0; m_h = 0; m_v = 0; m_ho = 0; m_vo = 0;
      e      = '0;
      e.hpos = 6'(SBASE);
      e.hblk = 1'b1;
      e.vblk = 1'b1;
      e.vsyn = 1'b1;
    end else if (PCEN) begin
      if (!m_started) begin
        m_started = 1;
      end else begin
        if (m_h == SHT - 1 && m_v == SVT - 1) begin
          m_ho = clampi(hoffs_sm, SHF, SHB);
          m_vo = clampi(voffs_sm, SVF, SVB);
        end
        m_h = m_h + 1;
        if (m_h == SHT) begin
          m_h = 0;
          m_v = (m_v + 1) % SVT;
        end
      end
      e      = decode();
      e.orgb = (m_prev.hblk || m_prev.vblk) ? 8'h00 : irgb_sm;
    end else begin
      e = m_prev;
    end
    m_prev = e;
    sb_q.push_back(e);
    @(posedge PCLK);
    #1;
    got = {hpos_sm, vpos_sm, hblk_sm, vblk_sm, hsyn_sm, vsyn_sm, lstart_sm, fstart_sm, orgb_sm};
    e = sb_q.pop_front();
    chk("sb_small", {6'd0, got}, {6'd0, e});
  endtask

  task automatic wait_fs_sm();
    int n = 0;
    while (fstart_sm !== 1'b1 && n < 1500) begin
      tick();
      n++;
    end
    chk("wait_fstart_sm", {31'd0, fstart_sm}, 32'd1);
  endtask

  // Scan one small frame from its FSTART, optionally changing offsets at tick
  // chg_at. Reports HSYN extent on line 10 and VSYN extent in lines.
  task automatic scan_frame(input int chg_at, input logic [3:0] nh, input logic [3:0] nv,
                            output int hf, output int hl, output int vf, output int vl);
    hf = -1; hl = -1; vf = -1; vl = -1;
    for (int i = 0; i < SHT * SVT; i++) begin
      if (i == chg_at) begin
        hoffs_sm = nh;
        voffs_sm = nv;
      end
      if (i / SHT == 10 && hsyn_sm) begin
        if (hf < 0) hf = i % SHT;
        hl = i % SHT;
      end
      if (i % SHT == 0 && !vsyn_sm) begin
        if (vf < 0) vf = i / SHT;
        vl = i / SHT;
      end
      tick();
    end
  endtask

  // ---------------- default-mode table ----------------
  typedef struct {
    int          k;
    logic [7:0]  rgb;
    logic [31:0] exp;
  } row_t;

  row_t rows[15];

  function automatic row_t mk(input int k, input logic [7:0] rgb, input int hp, input int vp,
                              input bit hb, input bit vb, input bit hs, input bit vs,
                              input bit ls, input bit fs, input logic [7:0] o);
    row_t r;
    r.k   = k;
    r.rgb = rgb;
    r.exp = {9'(hp), 9'(vp), hb, vb, hs, vs, ls, fs, o};
    return r;
  endfunction

  function automatic logic [31:0] got_df();
    return {hpos_df, vpos_df, hblk_df, vblk_df, hsyn_df, vsyn_df, lstart_df, fstart_df,
            orgb_df};
  endfunction

  int k, n, pc, hf, hl, vf, vl;

  initial begin
    //          k    rgb    hpos vpos hb vb hs vs ls fs orgb
    rows[0]  = mk(0,   8'hA5, 0,   0,  1, 1, 1, 1, 0, 0, 8'h00);
    rows[1]  = mk(1,   8'hA5, 0,   0,  0, 0, 1, 1, 1, 1, 8'h00);
    rows[2]  = mk(2,   8'h11, 1,   0,  0, 0, 1, 1, 0, 0, 8'h11);
    rows[3]  = mk(256, 8'h3C, 255, 0,  0, 0, 1, 1, 0, 0, 8'h3C);
    rows[4]  = mk(257, 8'h5A, 256, 0,  1, 0, 1, 1, 0, 0, 8'h5A);
    rows[5]  = mk(258, 8'hFF, 257, 0,  1, 0, 1, 1, 0, 0, 8'h00);
    rows[6]  = mk(280, 8'hA5, 279, 0,  1, 0, 1, 1, 0, 0, 8'h00);
    rows[7]  = mk(281, 8'hA5, 280, 0,  1, 0, 0, 1, 0, 0, 8'h00);
    rows[8]  = mk(312, 8'hA5, 311, 0,  1, 0, 0, 1, 0, 0, 8'h00);
    rows[9]  = mk(313, 8'hA5, 312, 0,  1, 0, 1, 1, 0, 0, 8'h00);
    rows[10] = mk(384, 8'hA5, 383, 0,  1, 0, 1, 1, 0, 0, 8'h00);
    rows[11] = mk(385, 8'hA5, 0,   1,  0, 0, 1, 1, 1, 0, 8'h00);
    rows[12] = mk(386, 8'h77, 1,   1,  0, 0, 1, 1, 0, 0, 8'h77);
    rows[13] = mk(641, 8'h42, 256, 1,  1, 0, 1, 1, 0, 0, 8'h42);
    rows[14] = mk(769, 8'hA5, 0,   2,  0, 0, 1, 1, 1, 0, 8'h00);

    // Reset, then PCEN held high.
    RESET = 1'b1;
    PCEN  = 1'b0;
    tick();
    RESET = 1'b0;
    PCEN  = 1'b1;
    k = 0;
    foreach (rows[i]) begin
      irgb_df = rows[i].rgb;
      while (k < rows[i].k) begin
        tick();
        k++;
      end
      chk($sformatf("table_k%0d", rows[i].k), got_df(), rows[i].exp);
    end

    // Offsets written mid-frame apply to the next frame only; clamping.
    wait_fs_sm();
    scan_frame(5 * SHT + 7, 4'd3, 4'hE, hf, hl, vf, vl);          // +3, -2
    chk("frame_a_sync", {8'(hf), 8'(hl), 8'(vf), 8'(vl)}, {8'd20, 8'd23, 8'd15, 8'd16});
    scan_frame(100, 4'h8, 4'd7, hf, hl, vf, vl);                  // -8, +7
    chk("frame_b_sync", {8'(hf), 8'(hl), 8'(vf), 8'(vl)}, {8'd23, 8'd26, 8'd13, 8'd14});
    scan_frame(SHT * SVT - 1, 4'd0, 4'd0, hf, hl, vf, vl);        // change on last tick
    chk("frame_c_clamp", {8'(hf), 8'(hl), 8'(vf), 8'(vl)}, {8'd16, 8'd19, 8'd19, 8'd20});
    scan_frame(-1, 4'd0, 4'd0, hf, hl, vf, vl);
    chk("frame_d_zero", {8'(hf), 8'(hl), 8'(vf), 8'(vl)}, {8'd20, 8'd23, 8'd15, 8'd16});

    // Frame period on the small mode.
    n = 0;
    do begin
      tick();
      n++;
    end while (fstart_sm !== 1'b1 && n < 2000);
    chk("fstart_period_sm", 32'(n), 32'(SHT * SVT));

    // PCEN 1-of-4, reset pulsed mid-frame while PCEN is low.
    pc = 0;
    n  = 0;
    while (vpos_sm !== 6'd10 && n < 3000) begin
      PCEN = (pc % 4 == 0);
      pc++;
      tick();
      n++;
    end
    chk("reach_vpos10", {26'd0, vpos_sm}, 32'd10);
    PCEN  = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("df_reset_state", got_df(), {9'd0, 9'd0, 6'b111100, 8'h00});
    chk("sm_reset_state", {6'd0, hpos_sm, vpos_sm, hblk_sm, vblk_sm, hsyn_sm, vsyn_sm,
                           lstart_sm, fstart_sm, orgb_sm},
        {6'd0, 6'd40, 6'd0, 6'b110100, 8'h00});
    for (int i = 0; i < 3; i++) tick();
    chk("sm_hold_after_reset", {6'd0, hpos_sm, vpos_sm, hblk_sm, vblk_sm, hsyn_sm, vsyn_sm,
                                lstart_sm, fstart_sm, orgb_sm},
        {6'd0, 6'd40, 6'd0, 6'b110100, 8'h00});
    PCEN = 1'b1;
    tick();
    chk("df_first_tick", got_df(), {9'd0, 9'd0, 6'b001111, 8'h00});
    chk("sm_first_tick", {6'd0, hpos_sm, vpos_sm, hblk_sm, vblk_sm, hsyn_sm, vsyn_sm,
                          lstart_sm, fstart_sm, orgb_sm},
        {6'd0, 6'd40, 6'd0, 6'b000111, 8'h00});

    // Random enables and offsets, scoreboard only.
    for (int i = 0; i < 3000; i++) begin
      PCEN     = ($urandom_range(0, 3) == 0);
      hoffs_sm = 4'($urandom);
      voffs_sm = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
